// File: rtl/prefix_parser_if.sv
// prefix_parser_if: byte-stream input, FIB prefix handoff and payload output of prefix_parser.
interface prefix_parser_if;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic        in_ready;
  logic [63:0] data_in_prefix;
  logic [5:0]  data_in_len;
  logic        data_ready;
  logic        fib_ack;
  logic        pkt_type;
  logic [7:0]  data_in;
  logic        payload_valid;
  logic        parse_err;
  modport master (
    output in_byte, in_valid, in_sop, in_eop, fib_ack,
    input  in_ready, data_in_prefix, data_in_len, data_ready, pkt_type, data_in, payload_valid, parse_err
  );
  modport slave (
    input  in_byte, in_valid, in_sop, in_eop, fib_ack,
    output in_ready, data_in_prefix, data_in_len, data_ready, pkt_type, data_in, payload_valid, parse_err
  );
endinterface

// File: rtl/prefix_parser.sv
// prefix_parser: extracts a typed name prefix for FIB lookup, then forwards payload bytes.
// Define PARSER_ERR_CNT_EN to add err_count, a saturating count of parse_err pulses.
module prefix_parser (
  input  logic clk,
  input  logic rst,
`ifdef PARSER_ERR_CNT_EN
  output logic [7:0] err_count,
`endif
  prefix_parser_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LEN, NAME, WAIT_ACK, PAYLOAD, DROP} state_t;
  state_t      r_state, w_next;
  logic        r_run, r_last_eop, r_type, r_rdy, r_perr, r_pv;
  logic [2:0]  r_len, r_cnt;
  logic [7:0]  r_din;
  logic [63:0] r_prefix;
  logic        w_xfer, w_type_ok, w_len_ok, w_err, w_ld_type, w_ld_len, w_wr_name, w_fin, w_pay, w_ack;
  // r_run keeps in_ready low until the first edge after reset release
  assign bus.in_ready       = r_run && r_state != WAIT_ACK;
  assign bus.data_in_prefix = r_prefix;
  assign bus.data_in_len    = {r_len, 3'b000};
  assign bus.data_ready     = r_rdy;
  assign bus.pkt_type       = r_type;
  assign bus.data_in        = r_din;
  assign bus.payload_valid  = r_pv;
  assign bus.parse_err      = r_perr;
  assign w_xfer    = bus.in_valid && bus.in_ready;
  assign w_type_ok = bus.in_byte == 8'h05 || bus.in_byte == 8'h06;
  assign w_len_ok  = bus.in_byte != 8'd0 && bus.in_byte < 8'd8;
  assign w_ack     = r_state == WAIT_ACK && bus.fib_ack;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_ld_type = 1'b0;
    w_ld_len  = 1'b0;
    w_wr_name = 1'b0;
    w_fin     = 1'b0;
    w_pay     = 1'b0;
    unique case (r_state)
      IDLE, PAYLOAD: if (w_xfer) begin
        if (bus.in_sop) begin
          // a sop inside a payload restarts parsing on this byte
          w_err     = bus.in_eop || !w_type_ok || r_state == PAYLOAD;
          w_ld_type = !bus.in_eop && w_type_ok;
          w_next    = bus.in_eop ? IDLE : w_type_ok ? LEN : DROP;
        end else if (r_state == PAYLOAD) begin
          w_pay  = 1'b1;
          w_next = bus.in_eop ? IDLE : PAYLOAD;
        end
      end
      LEN: if (w_xfer) begin
        w_ld_len = !bus.in_eop && w_len_ok;
        w_err    = !w_ld_len;
        w_next   = bus.in_eop ? IDLE : w_len_ok ? NAME : DROP;
      end
      NAME: if (w_xfer) begin
        w_wr_name = 1'b1;
        w_fin     = r_cnt == r_len - 3'd1;
        w_err     = !w_fin && bus.in_eop;
        w_next    = w_fin ? WAIT_ACK : bus.in_eop ? IDLE : NAME;
      end
      WAIT_ACK: w_next = bus.fib_ack ? (r_last_eop ? IDLE : PAYLOAD) : WAIT_ACK;
      DROP:     w_next = w_xfer && bus.in_eop ? IDLE : DROP;
      default:  w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_run      <= 1'b0;
      r_last_eop <= 1'b0;
      r_type     <= 1'b0;
      r_rdy      <= 1'b0;
      r_perr     <= 1'b0;
      r_pv       <= 1'b0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_din      <= '0;
      r_prefix   <= '0;
    end else begin
      r_run  <= 1'b1;
      r_perr <= w_err;
      r_pv   <= w_pay;
      if (w_pay) r_din <= bus.in_byte;
      if (w_ld_type) r_type <= bus.in_byte == 8'h06;
      if (w_ld_len) begin
        r_len    <= bus.in_byte[2:0];
        r_cnt    <= '0;
        r_prefix <= '0;
      end
      // name byte i lands at bits [63-8i -: 8]
      if (w_wr_name) begin
        r_prefix[{~r_cnt, 3'b111} -: 8] <= bus.in_byte;
        r_cnt <= r_cnt + 3'd1;
      end
      if (w_fin) begin
        r_rdy      <= 1'b1;
        r_last_eop <= bus.in_eop;
      end
      if (w_ack) r_rdy <= 1'b0;
    end
`ifdef PARSER_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) err_count <= '0;
    else if (w_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
`endif
endmodule

// File: tb/tb_prefix_parser.sv
// tb_prefix_parser: directed and randomized packets checked against a packet-level reference model.
module tb_prefix_parser;
  typedef struct packed { logic [63:0] p; logic [5:0] l; logic t; } rec_t;
  logic clk = 1'b0;
  logic rst;
  logic auto_ack, ack_auto, man_ack;
  int   ack_dly;
  int   n_chk = 0, n_pass = 0;
  int   n_err = 0, n_rdy_bad = 0, err_base = 0, rd_pfx = 0, rd_pay = 0;
  int   exp_err = 0, tot_err = 0;
  logic prev_dr;
  rec_t got_pfx[$], exp_pfx[$];
  logic [7:0] got_pay[$], exp_pay[$], pkt[$];
  prefix_parser_if bus();
`ifdef PARSER_ERR_CNT_EN
  logic [7:0] err_count;
  prefix_parser dut (.clk(clk), .rst(rst), .err_count(err_count), .bus(bus.slave));
`else
  prefix_parser dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif
  assign bus.fib_ack = ack_auto | man_ack;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " in_ready"}, bus.in_ready, 0);
    chk({tag, " prefix"}, bus.data_in_prefix, 0);
    chk({tag, " len"}, bus.data_in_len, 0);
    chk({tag, " data_ready"}, bus.data_ready, 0);
    chk({tag, " pkt_type"}, bus.pkt_type, 0);
    chk({tag, " data_in"}, bus.data_in, 0);
    chk({tag, " payload_valid"}, bus.payload_valid, 0);
    chk({tag, " parse_err"}, bus.parse_err, 0);
`ifdef PARSER_ERR_CNT_EN
    chk({tag, " err_count"}, err_count, 0);
`endif
  endtask
  // entered and left at posedge+1; holds the byte until the parser takes it
  task automatic put(input logic [7:0] b, input logic s, input logic e);
    int t = 0;
    logic acc = 1'b0;
    while ($urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_byte = b; bus.in_sop = s; bus.in_eop = e; bus.in_valid = 1'b1;
    while (!acc && t < 200) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk); #1;
      t++;
    end
    bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    if (!acc) chk("put_timeout accepted", 0, 1);
  endtask
  task automatic send(input logic [7:0] b[$]);
    foreach (b[i]) put(b[i], i == 0, i == b.size() - 1);
  endtask
  task automatic drain();
    int k = 0;
    repeat (2) @(negedge clk);
    while (bus.data_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (bus.data_ready) chk("drain_timeout data_ready", 1, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
  endtask
  // one complete sop..eop packet started from idle: either one error or a prefix plus payload
  task automatic model(input logic [7:0] b[$]);
    int n = b.size();
    rec_t r;
    if (n < 2 || (b[0] != 8'h05 && b[0] != 8'h06) || b[1] == 8'd0 || b[1] > 8'd7 || n < 2 + int'(b[1])) begin
      exp_err++;
      tot_err++;
    end else begin
      r.p = '0;
      for (int i = 0; i < int'(b[1]); i++) r.p = r.p | (64'(b[2+i]) << (56 - 8*i));
      r.l = 6'(8 * int'(b[1]));
      r.t = b[0] == 8'h06;
      exp_pfx.push_back(r);
      for (int i = 2 + int'(b[1]); i < n; i++) exp_pay.push_back(b[i]);
    end
  endtask
  task automatic send_model(input logic [7:0] b[$]);
    model(b);
    send(b);
    drain();
  endtask
  task automatic resync();
    rd_pfx = got_pfx.size();
    rd_pay = got_pay.size();
    err_base = n_err;
    exp_pfx.delete();
    exp_pay.delete();
    exp_err = 0;
  endtask
  task automatic verify(input string tag);
    chk({tag, " prefix_count"}, got_pfx.size() - rd_pfx, exp_pfx.size());
    foreach (exp_pfx[i]) if (rd_pfx + i < got_pfx.size()) begin
      chk({tag, " prefix"}, got_pfx[rd_pfx+i].p, exp_pfx[i].p);
      chk({tag, " len"}, got_pfx[rd_pfx+i].l, exp_pfx[i].l);
      chk({tag, " pkt_type"}, got_pfx[rd_pfx+i].t, exp_pfx[i].t);
    end
    chk({tag, " payload_count"}, got_pay.size() - rd_pay, exp_pay.size());
    foreach (exp_pay[i]) if (rd_pay + i < got_pay.size())
      chk({tag, " payload"}, got_pay[rd_pay+i], exp_pay[i]);
    chk({tag, " parse_err_pulses"}, n_err - err_base, exp_err);
    chk({tag, " in_ready_while_data_ready"}, n_rdy_bad, 0);
`ifdef PARSER_ERR_CNT_EN
    chk({tag, " err_count"}, err_count, tot_err > 255 ? 255 : tot_err);
`endif
    resync();
  endtask
  task automatic rand_pkt();
    logic [7:0] b[$];
    int kind = $urandom_range(0, 9);
    int len = $urandom_range(1, 7);
    int np = $urandom_range(0, 4);
    int keep;
    logic [7:0] typ = $urandom_range(0, 1) ? 8'h06 : 8'h05;
    if (kind == 0) typ = 8'h07 + 8'($urandom_range(0, 200));
    if (kind == 1) len = $urandom_range(0, 1) ? 0 : $urandom_range(8, 255);
    b.push_back(typ);
    if (kind != 2) begin
      b.push_back(8'(len));
      for (int i = 0; i < ((len >= 1 && len <= 7) ? len : 0); i++) b.push_back(8'($urandom));
      for (int i = 0; i < np; i++) b.push_back(8'($urandom));
    end
    if (kind == 3) begin
      keep = 2 + $urandom_range(0, len - 1);
      while (b.size() > keep) void'(b.pop_back());
    end
    if ($urandom_range(0, 3) == 0) put(8'($urandom), 1'b0, 1'($urandom));
    send_model(b);
    verify("rand");
  endtask
  initial forever begin
    @(negedge clk);
    if (!rst) prev_dr = 1'b0;
    else begin
      if (bus.data_ready && !prev_dr) got_pfx.push_back({bus.data_in_prefix, bus.data_in_len, bus.pkt_type});
      if (bus.data_ready && bus.in_ready) n_rdy_bad++;
      if (bus.payload_valid) got_pay.push_back(bus.data_in);
      if (bus.parse_err) n_err++;
      prev_dr = bus.data_ready;
    end
  end
  initial begin
    ack_auto = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && rst && bus.data_ready) begin
        repeat (ack_dly < 0 ? int'($urandom_range(0, 4)) : ack_dly) @(posedge clk);
        #1 ack_auto = 1'b1;
        @(posedge clk); #1 ack_auto = 1'b0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [63:0] snap;
    int k;
    rst = 1'b0; auto_ack = 1'b1; ack_dly = -1; man_ack = 1'b0;
    bus.in_byte = '0; bus.in_valid = 1'b0; bus.in_sop = 1'b0; bus.in_eop = 1'b0;
    #12 chk_zero("reset");
    #10 rst = 1'b1;
    #1 chk("in_ready before first edge", bus.in_ready, 0);
    @(posedge clk); #1 chk("in_ready after first edge", bus.in_ready, 1);
    ack_dly = 2;
    pkt = {8'h06, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h11, 8'h22};
    send_model(pkt);
    if (got_pfx.size() > rd_pfx) begin
      chk("basic prefix const", got_pfx[rd_pfx].p, 64'hAABBCC0000000000);
      chk("basic len const", got_pfx[rd_pfx].l, 24);
      chk("basic type const", got_pfx[rd_pfx].t, 1);
    end
    verify("basic");
    ack_dly = -1;
    pkt = {8'h05, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_model(pkt);
    verify("l7_eop_on_name");
    chk("l7 idle in_ready", bus.in_ready, 1);
    pkt = {8'h06, 8'h00, 8'h01, 8'h02};
    send_model(pkt);
    pkt = {8'h06, 8'h08, 8'h01, 8'h02, 8'h03};
    send_model(pkt);
    verify("bad_len");
    auto_ack = 1'b0;
    pkt = {8'h06, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44};
    model(pkt);
    fork
      send(pkt);
      begin
        k = 0;
        while (!bus.data_ready && k < 100) begin @(negedge clk); k++; end
        chk("hold data_ready seen", bus.data_ready, 1);
        snap = bus.data_in_prefix;
        repeat (10) begin
          @(negedge clk);
          chk("hold in_ready", bus.in_ready, 0);
          chk("hold prefix", bus.data_in_prefix, snap);
          chk("hold data_ready", bus.data_ready, 1);
        end
        @(posedge clk); #1 man_ack = 1'b1;
        @(posedge clk); #1 man_ack = 1'b0;
      end
    join
    drain();
    verify("ack_hold");
    @(posedge clk); #1 man_ack = 1'b1;
    @(posedge clk); #1 man_ack = 1'b0;
    @(negedge clk);
    chk("stray ack data_ready", bus.data_ready, 0);
    chk("stray ack in_ready", bus.in_ready, 1);
    @(posedge clk); #1 auto_ack = 1'b1;
    pkt = {8'h06, 8'h04, 8'hA1, 8'hB2};
    send_model(pkt);
    pkt = {8'h05, 8'h02, 8'hC3, 8'hD4, 8'hE5};
    send_model(pkt);
    verify("early_eop");
    put(8'h06, 1'b1, 1'b0); put(8'h01, 1'b0, 1'b0); put(8'hAA, 1'b0, 1'b0); put(8'h11, 1'b0, 1'b0);
    exp_pfx.push_back({64'hAA00000000000000, 6'd8, 1'b1});
    exp_pay.push_back(8'h11);
    exp_err++; tot_err++;
    pkt = {8'h05, 8'h02, 8'hBB, 8'hCC, 8'h33};
    send_model(pkt);
    verify("sop_in_payload");
    put(8'h06, 1'b1, 1'b0); put(8'h01, 1'b0, 1'b0); put(8'h5A, 1'b0, 1'b0);
    put(8'h11, 1'b0, 1'b0); put(8'h22, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk_zero("mid_payload_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    #1 chk("post reset in_ready before edge", bus.in_ready, 0);
    @(posedge clk); #1 chk("post reset in_ready", bus.in_ready, 1);
    tot_err = 0;
    resync();
    put(8'h33, 1'b0, 1'b0); put(8'h44, 1'b0, 1'b1);
    pkt = {8'h06, 8'h02, 8'h77, 8'h88, 8'h99};
    send_model(pkt);
    verify("after_reset");
    for (int i = 0; i < 150; i++) rand_pkt();
`ifdef PARSER_ERR_CNT_EN
    for (int i = 0; i < 260; i++) begin
      put(8'($urandom), 1'b1, 1'b1);
      exp_err++; tot_err++;
    end
    drain();
    verify("err_saturate");
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
